// File: rtl/gc_channel_arbiter.sv
// gc_channel_arbiter: shares one flash channel between host traffic and
// garbage collection (GC) page moves.
//
// state | meaning
// IDLE  | channel free, resolves next owner
// HOST  | host operation owns the channel until host_done
// GC    | GC page move owns the channel until move_done_flag
//
// GC urgency (gc_interrupt) follows clean_num with low/high hysteresis.
// While GC is urgent and pending, the host is held off. Otherwise a
// starvation counter forces GC in after STARVE_LIMIT consecutive host grants
// taken while GC was waiting.
//
// Optional build macro GC_WATCHDOG_EN: adds an 8-bit ownership watchdog that
// forces the channel back to IDLE and sets a sticky timeout_err. Without it,
// timeout_err is tied low.

module gc_channel_arbiter #(
    parameter int FIFO_SIZE_BIT_NUM = 4,
    parameter int GC_LOW_THRESH     = 2,
    parameter int GC_HIGH_THRESH    = 6,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         host_req,
    input  logic                         host_done,
    input  logic                         gc_request,
    input  logic                         move_done_flag,
    input  logic [FIFO_SIZE_BIT_NUM-1:0] clean_num,
    output logic                         host_grant,
    output logic                         move_flag,
    output logic                         gc_start,
    output logic                         gc_interrupt,
    output logic                         timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOST = 2'd1;
    localparam logic [1:0] ST_GC   = 2'd2;

    localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_LOW_THRESH  = FIFO_SIZE_BIT_NUM'(GC_LOW_THRESH);
    localparam logic [FIFO_SIZE_BIT_NUM-1:0] LP_HIGH_THRESH = FIFO_SIZE_BIT_NUM'(GC_HIGH_THRESH);
    localparam logic [3:0]                   LP_STARVE_LIM  = 4'(STARVE_LIMIT);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [3:0] r_starve_cnt;
    logic       r_gc_int;
    logic       r_gc_start;
    logic       w_done_match;
    logic       w_wd_expire;

    // The done pulse only counts when it matches the current owner; stray
    // pulses from the other side are ignored.
    assign w_done_match = ((r_state == ST_HOST) && host_done) ||
                          ((r_state == ST_GC)   && move_done_flag);

`ifdef GC_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic       r_timeout;

    assign w_wd_expire = (r_state != ST_IDLE) && (r_wd_cnt == 8'hFF);

    // Watchdog counter: runs during any ownership, restarts when IDLE is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wd_cnt <= 8'd0;
        end else if ((r_state == ST_IDLE) || (w_next == ST_IDLE)) begin
            r_wd_cnt <= 8'd0;
        end else if (r_wd_cnt != 8'hFF) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end
    end

    // Sticky timeout flag; a done pulse arriving on the expiry cycle wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timeout <= 1'b0;
        end else if (w_wd_expire && !w_done_match) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state resolution; IDLE priority puts urgent GC first, then the
    // starvation escape, then the host, then background GC.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (gc_request && r_gc_int) begin
                    w_next = ST_GC;
                end else if (gc_request && (r_starve_cnt == LP_STARVE_LIM)) begin
                    w_next = ST_GC;
                end else if (host_req) begin
                    w_next = ST_HOST;
                end else if (gc_request) begin
                    w_next = ST_GC;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_HOST: begin
                if (host_done || w_wd_expire) begin
                    w_next = ST_IDLE;
                end
            end
            ST_GC: begin
                if (move_done_flag || w_wd_expire) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Starvation counter: counts host grants taken while GC was waiting.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve_cnt <= 4'd0;
        end else if ((r_state == ST_IDLE) && (w_next == ST_HOST)) begin
            if (!gc_request) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt < LP_STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else if ((r_state == ST_IDLE) && (w_next == ST_GC)) begin
            r_starve_cnt <= 4'd0;
        end
    end

    // Urgency level with hysteresis between the low and high thresholds.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gc_int <= 1'b0;
        end else if (clean_num <= LP_LOW_THRESH) begin
            r_gc_int <= 1'b1;
        end else if (clean_num >= LP_HIGH_THRESH) begin
            r_gc_int <= 1'b0;
        end
    end

    // One-cycle start pulse aligned with the first GC cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gc_start <= 1'b0;
        end else begin
            r_gc_start <= (r_state == ST_IDLE) && (w_next == ST_GC);
        end
    end

    assign host_grant   = (r_state == ST_HOST);
    assign move_flag    = (r_state == ST_GC);
    assign gc_start     = r_gc_start;
    assign gc_interrupt = r_gc_int;

endmodule

// File: tb/tb_gc_channel_arbiter.sv
// Directed bench for gc_channel_arbiter with hand-computed expectations.
module tb_gc_channel_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       host_req = 1'b0;
    logic       host_done = 1'b0;
    logic       gc_request = 1'b0;
    logic       move_done_flag = 1'b0;
    logic [3:0] clean_num = 4'd10;
    logic       host_grant;
    logic       move_flag;
    logic       gc_start;
    logic       gc_interrupt;
    logic       timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    gc_channel_arbiter dut (
        .CLK            (CLK),
        .RST            (RST),
        .host_req       (host_req),
        .host_done      (host_done),
        .gc_request     (gc_request),
        .move_done_flag (move_done_flag),
        .clean_num      (clean_num),
        .host_grant     (host_grant),
        .move_flag      (move_flag),
        .gc_start       (gc_start),
        .gc_interrupt   (gc_interrupt),
        .timeout_err    (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        chk("rst_host_grant", host_grant, 0);
        chk("rst_move_flag", move_flag, 0);
        chk("rst_gc_start", gc_start, 0);
        chk("rst_gc_int", gc_interrupt, 0);
        chk("rst_timeout", timeout_err, 0);

        // Stray done pulses in IDLE are ignored
        host_done = 1'b1; move_done_flag = 1'b1;
        tick();
        host_done = 1'b0; move_done_flag = 1'b0;
        chk("idle_stray_done_host", host_grant, 0);
        chk("idle_stray_done_gc", move_flag, 0);

        // Basic host grant, release, re-grant
        host_req = 1'b1;
        tick();
        chk("host_grant_lat1", host_grant, 1);
        chk("host_no_move", move_flag, 0);
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        chk("host_done_idle", host_grant, 0);
        tick();
        chk("host_regrant", host_grant, 1);

        // In HOST: move_done_flag ignored, host_req drop does not end ownership
        host_req = 1'b0;
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
        chk("host_ignores_move_done", host_grant, 1);
        tick(); tick();
        chk("host_holds_without_req", host_grant, 1);
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        chk("host_release2", host_grant, 0);

        // Starvation: 8 host grants, then GC with gc_start
        host_req = 1'b1; gc_request = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("starve_host_grant_%0d", i), host_grant, 1);
            chk($sformatf("starve_no_move_%0d", i), move_flag, 0);
            host_done = 1'b1;
            tick();
            host_done = 1'b0;
            chk($sformatf("starve_idle_%0d", i), host_grant, 0);
        end
        tick();
        chk("starve_gc_grant", move_flag, 1);
        chk("starve_gc_no_host", host_grant, 0);
        chk("starve_gc_start", gc_start, 1);
        // host_done during GC must be ignored
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        chk("gc_start_one_cycle", gc_start, 0);
        chk("gc_ignores_host_done", move_flag, 1);
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
        chk("gc_done_idle", move_flag, 0);
        tick();
        chk("starve_cleared_host_next", host_grant, 1);
        host_done = 1'b1; host_req = 1'b0; gc_request = 1'b0;
        tick();
        host_done = 1'b0;
        chk("after_starve_idle", host_grant, 0);

        // Urgency hysteresis and urgent GC priority
        clean_num = 4'd7;
        tick();
        chk("int_at_7", gc_interrupt, 0);
        clean_num = 4'd3;
        tick();
        chk("int_at_3", gc_interrupt, 0);
        clean_num = 4'd2;
        tick();
        chk("int_at_2", gc_interrupt, 1);
        host_req = 1'b1; gc_request = 1'b1;
        tick();
        chk("urgent_gc_grant", move_flag, 1);
        chk("urgent_no_host", host_grant, 0);
        chk("urgent_gc_start", gc_start, 1);
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
        chk("urgent_gc_done", move_flag, 0);
        tick();
        chk("urgent_gc_again", move_flag, 1);
        move_done_flag = 1'b1; gc_request = 1'b0;
        tick();
        move_done_flag = 1'b0;
        chk("urgent_gc_done2", move_flag, 0);
        tick();
        chk("urgent_host_when_no_gc", host_grant, 1);
        host_done = 1'b1; host_req = 1'b0;
        tick();
        host_done = 1'b0;
        chk("urgent_host_done", host_grant, 0);
        clean_num = 4'd5;
        tick();
        chk("int_hold_at_5", gc_interrupt, 1);
        clean_num = 4'd6;
        tick();
        chk("int_clear_at_6", gc_interrupt, 0);
        clean_num = 4'd10;

        // Reset during GC abandons ownership; later done ignored
        gc_request = 1'b1;
        tick();
        chk("bg_gc_grant", move_flag, 1);
        gc_request = 1'b0;
        RST = 1'b1; move_done_flag = 1'b1; host_req = 1'b1; clean_num = 4'd1;
        tick();
        move_done_flag = 1'b0;
        chk("rst_gc_move_flag", move_flag, 0);
        chk("rst_gc_host_grant", host_grant, 0);
        chk("rst_gc_gc_start", gc_start, 0);
        chk("rst_gc_int_low", gc_interrupt, 0);
        chk("rst_gc_timeout", timeout_err, 0);
        tick();
        chk("rst_ignores_host_req", host_grant, 0);
        RST = 1'b0; host_req = 1'b0; clean_num = 4'd10;
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
        chk("post_rst_move_done_ignored", move_flag, 0);
        chk("post_rst_idle_host", host_grant, 0);

        // Long host ownership: watchdog behaviour depends on the build
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        chk("wd_host_grant", host_grant, 1);
`ifdef GC_WATCHDOG_EN
        begin
            int cyc;
            cyc = 0;
            while (host_grant && cyc < 400) begin
                tick();
                cyc++;
            end
            chk("wd_released_in_budget", (cyc < 400) ? 32'd1 : 32'd0, 1);
            chk("wd_timeout_set", timeout_err, 1);
            repeat (5) tick();
            chk("wd_timeout_sticky", timeout_err, 1);
            RST = 1'b1;
            tick();
            RST = 1'b0;
            chk("wd_timeout_rst_clear", timeout_err, 0);
        end
`else
        repeat (1000) tick();
        chk("nowd_host_held", host_grant, 1);
        chk("nowd_timeout_low", timeout_err, 0);
        host_done = 1'b1;
        tick();
        host_done = 1'b0;
        chk("nowd_host_done", host_grant, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
